// File: rtl/vga_pkg.sv
// Shared constants for the 640x480@60 video path: geometry, pattern codes, colours.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] MODE_BARS     = 2'd0;
    localparam logic [1:0] MODE_CHECKER  = 2'd1;
    localparam logic [1:0] MODE_GRADIENT = 2'd2;
    localparam logic [1:0] MODE_BOX      = 2'd3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE   = 12'hFFF;
    localparam rgb_t RGB_BLACK   = 12'h000;
    localparam rgb_t RGB_BG_BLUE = 12'h008;

    // Colour-bar lookup: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_rgb(input logic [2:0] idx);
        rgb_t c;
        c.r = (idx == 3'd0 || idx == 3'd1 || idx == 3'd4 || idx == 3'd5) ? 4'hF : 4'h0;
        c.g = (idx <= 3'd3) ? 4'hF : 4'h0;
        c.b = (idx[0] == 1'b0) ? 4'hF : 4'h0;
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state; advances one step per frame-start pulse.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACT    = H_ACTIVE,
    parameter int V_ACT    = V_ACTIVE,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       step_i,
    output logic [9:0] bx_o,
    output logic [9:0] by_o
);

    localparam logic [9:0] X_TURN = 10'(H_ACT - BOX_SIZE - BOX_STEP);
    localparam logic [9:0] X_MAX  = 10'(H_ACT - BOX_SIZE);
    localparam logic [9:0] Y_TURN = 10'(V_ACT - BOX_SIZE - BOX_STEP);
    localparam logic [9:0] Y_MAX  = 10'(V_ACT - BOX_SIZE);
    localparam logic [9:0] STEP   = 10'(BOX_STEP);

    logic [9:0] bx, by, bx_nxt, by_nxt;
    logic       neg_x, neg_y, neg_x_nxt, neg_y_nxt;

    // Clamp to the wall on the turning step so the box never overshoots.
    always_comb begin
        bx_nxt    = bx;
        neg_x_nxt = neg_x;
        if (!neg_x) begin
            if (bx >= X_TURN) begin
                bx_nxt    = X_MAX;
                neg_x_nxt = 1'b1;
            end else begin
                bx_nxt = bx + STEP;
            end
        end else if (bx <= STEP) begin
            bx_nxt    = '0;
            neg_x_nxt = 1'b0;
        end else begin
            bx_nxt = bx - STEP;
        end
    end

    always_comb begin
        by_nxt    = by;
        neg_y_nxt = neg_y;
        if (!neg_y) begin
            if (by >= Y_TURN) begin
                by_nxt    = Y_MAX;
                neg_y_nxt = 1'b1;
            end else begin
                by_nxt = by + STEP;
            end
        end else if (by <= STEP) begin
            by_nxt    = '0;
            neg_y_nxt = 1'b0;
        end else begin
            by_nxt = by - STEP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            bx    <= '0;
            by    <= '0;
            neg_x <= 1'b0;
            neg_y <= 1'b0;
        end else if (step_i) begin
            bx    <= bx_nxt;
            by    <= by_nxt;
            neg_x <= neg_x_nxt;
            neg_y <= neg_y_nxt;
        end
    end

    assign bx_o = bx;
    assign by_o = by;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage: two-cycle matched pipeline for RGB, syncs and active.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       active_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [1:0] mode_i,
    output logic [3:0] red_o,
    output logic [3:0] green_o,
    output logic [3:0] blue_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       active_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [9:0] x1, y1, bx, by;
    logic       act1, hs1, vs1;
    logic [1:0] mode_q;
    logic       frame_start;
    logic [2:0] bar_idx;
    logic       in_box;
    rgb_t       colour, rgb_q;

    assign frame_start = active_i && (x_i == '0) && (y_i == '0);

    vga_box_mover #(
        .H_ACT(H_ACTIVE), .V_ACT(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)
    ) u_box (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .step_i  (frame_start),
        .bx_o    (bx),
        .by_o    (by)
    );

    // Stage 1: capture coordinates/syncs; mode and box move only at frame start.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            x1     <= '0;
            y1     <= '0;
            act1   <= 1'b0;
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            mode_q <= MODE_BARS;
        end else begin
            x1   <= x_i;
            y1   <= y_i;
            act1 <= active_i;
            hs1  <= hsync_i;
            vs1  <= vsync_i;
            if (frame_start) mode_q <= mode_i;
        end
    end

    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++)
            if ({1'b0, x1} >= 11'(k * BAR_W)) bar_idx = 3'(k);
    end

    assign in_box = ({1'b0, x1} >= {1'b0, bx}) && ({1'b0, x1} < {1'b0, bx} + 11'(BOX_SIZE)) &&
                    ({1'b0, y1} >= {1'b0, by}) && ({1'b0, y1} < {1'b0, by} + 11'(BOX_SIZE));

    always_comb begin
        colour = RGB_BLACK;
        if (act1) begin
            case (mode_q)
                MODE_BARS:     colour = bar_rgb(bar_idx);
                MODE_CHECKER:  colour = (x1[5] ^ y1[5]) ? RGB_WHITE : RGB_BLACK;
                MODE_GRADIENT: colour = {x1[9:6], y1[8:5], ~x1[9:6]};
                default:       colour = in_box ? RGB_WHITE : RGB_BG_BLUE;
            endcase
        end
    end

    // Stage 2: colour and delayed syncs leave together.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rgb_q    <= RGB_BLACK;
            hsync_o  <= 1'b1;
            vsync_o  <= 1'b1;
            active_o <= 1'b0;
        end else begin
            rgb_q    <= colour;
            hsync_o  <= hs1;
            vsync_o  <= vs1;
            active_o <= act1;
        end
    end

    assign red_o   = rgb_q.r;
    assign green_o = rgb_q.g;
    assign blue_o  = rgb_q.b;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset, latency, all four patterns, box bounce.
module tb_vga_pattern_gen;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [9:0] x_i, y_i;
    logic       active_i, hsync_i, vsync_i;
    logic [1:0] mode_i;
    logic [3:0] red_o, green_o, blue_o;
    logic       hsync_o, vsync_o, active_o;

    int n_assert = 0;
    int n_fail   = 0;

    vga_pattern_gen dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .x_i(x_i), .y_i(y_i),
        .active_i(active_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .mode_i(mode_i),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o)
    );

    always #20 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input int x, input int y, input logic act, input logic hs, input logic vs);
        x_i      = 10'(x);
        y_i      = 10'(y);
        active_i = act;
        hsync_i  = hs;
        vsync_i  = vs;
    endtask

    task automatic idle();
        set_in(700, 500, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [11:0] rgb, input logic hs, input logic vs,
                       input logic act);
        n_assert++;
        assert ({red_o, green_o, blue_o, hsync_o, vsync_o, active_o} === {rgb, hs, vs, act})
        else begin
            n_fail++;
            $error("FAIL %s: got rgb=%h hs=%b vs=%b act=%b, expected rgb=%h hs=%b vs=%b act=%b",
                   tag, {red_o, green_o, blue_o}, hsync_o, vsync_o, active_o, rgb, hs, vs, act);
        end
    endtask

    // One visible pixel followed by blanking; checked once it reaches the outputs.
    task automatic px_chk(input string tag, input int x, input int y, input logic [11:0] rgb);
        set_in(x, y, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk(tag, rgb, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic frame_start();
        set_in(0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
    endtask

    // Triangle wave: climbs 2/frame to the far wall (lim-32), then descends.
    function automatic int exp_pos(input int n, input int lim);
        int peak = lim - 32;
        return (n <= peak / 2) ? 2 * n : peak - 2 * (n - peak / 2);
    endfunction

    initial begin
        int ex, ey;
        reset_ni = 1'b0;
        mode_i   = 2'd0;
        set_in(0, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("reset_1", 12'h000, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("reset_3", 12'h000, 1'b1, 1'b1, 1'b0);

        // Frame 1: bars, back-to-back pixels to prove the 2-cycle latency.
        reset_ni = 1'b1;
        set_in(0, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("post_release", 12'h000, 1'b1, 1'b1, 1'b0);
        set_in(79, 0, 1'b1, 1'b0, 1'b1);
        tick(); chk("bar_x0", 12'hFFF, 1'b1, 1'b1, 1'b1);
        set_in(80, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x79", 12'hFFF, 1'b0, 1'b1, 1'b1);
        set_in(240, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x80", 12'hFF0, 1'b1, 1'b1, 1'b1);
        set_in(320, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x240", 12'h0F0, 1'b1, 1'b1, 1'b1);
        set_in(400, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x320", 12'hF0F, 1'b1, 1'b1, 1'b1);
        set_in(559, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x400", 12'hF00, 1'b1, 1'b1, 1'b1);
        set_in(560, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x559", 12'h00F, 1'b1, 1'b1, 1'b1);
        set_in(639, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("bar_x560", 12'h000, 1'b1, 1'b1, 1'b1);
        set_in(700, 0, 1'b0, 1'b0, 1'b1);
        tick(); chk("bar_x639", 12'h000, 1'b1, 1'b1, 1'b1);
        idle();
        tick(); chk("blank_hs0", 12'h000, 1'b0, 1'b1, 1'b0);
        set_in(10, 5, 1'b1, 1'b1, 1'b0);
        tick(); chk("blank_hs1", 12'h000, 1'b1, 1'b1, 1'b0);
        idle();
        tick(); chk("vsync_low", 12'hFFF, 1'b1, 1'b0, 1'b1);

        // mode_i is ignored mid-frame.
        mode_i = 2'd1;
        px_chk("latch_32_100", 32, 100, 12'hFFF);
        px_chk("latch_200_101", 200, 101, 12'h0FF);

        // Frame 2: checker takes effect from the frame-start pixel.
        set_in(0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        mode_i = 2'd0;
        set_in(32, 0, 1'b1, 1'b1, 1'b1);
        tick(); chk("chk_0_0", 12'h000, 1'b1, 1'b1, 1'b1);
        idle();
        tick(); chk("chk_32_0", 12'hFFF, 1'b1, 1'b1, 1'b1);
        px_chk("chk_32_32", 32, 32, 12'h000);

        // Frame 3: gradient.
        mode_i = 2'd2;
        set_in(0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(400, 300, 1'b1, 1'b1, 1'b1);
        tick(); chk("grad_0_0", 12'h00F, 1'b1, 1'b1, 1'b1);
        set_in(639, 479, 1'b1, 1'b1, 1'b1);
        tick(); chk("grad_400_300", 12'h699, 1'b1, 1'b1, 1'b1);
        idle();
        tick(); chk("grad_639_479", 12'h9E6, 1'b1, 1'b1, 1'b1);

        // Frames 4..310: box, tracking both bounces.
        mode_i = 2'd3;
        for (int n = 4; n <= 310; n++) begin
            frame_start();
            ex = exp_pos(n, 640);
            ey = exp_pos(n, 480);
            px_chk($sformatf("box_in_f%0d", n), ex, ey, 12'hFFF);
            px_chk($sformatf("box_far_f%0d", n), ex + 31, ey + 31, 12'hFFF);
            px_chk($sformatf("box_right_f%0d", n), ex + 32, ey, 12'h008);
            px_chk($sformatf("box_below_f%0d", n), ex, ey + 32, 12'h008);
            if (ex > 0) px_chk($sformatf("box_left_f%0d", n), ex - 1, ey, 12'h008);
            if (n == 10) begin
                px_chk("f10_20_20", 20, 20, 12'hFFF);
                px_chk("f10_52_20", 52, 20, 12'h008);
                px_chk("f10_19_20", 19, 20, 12'h008);
            end
        end

        // Reset mid-frame: outputs clear on the next edge, mode and box restart.
        set_in(300, 100, 1'b1, 1'b0, 1'b0);
        tick();
        reset_ni = 1'b0;
        tick(); chk("midrst", 12'h000, 1'b1, 1'b1, 1'b0);
        idle();
        tick();
        reset_ni = 1'b1;
        tick(); chk("midrst_rel", 12'h000, 1'b1, 1'b1, 1'b0);
        px_chk("rst_mode_bars", 100, 5, 12'hFF0);
        frame_start();
        px_chk("rst_box_2_2", 2, 2, 12'hFFF);
        px_chk("rst_box_1_2", 1, 2, 12'h008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-colour stage that sits directly downstream of the 640x480@60 timing counters.
- Consumes per-pixel coordinates, the active-video flag and the raw sync levels, all on the pixel clock.
- Produces 4-bit-per-channel RGB plus syncs and active flag, all delayed by one matched latency.
- Provides four selectable test patterns, one of which is an animated bouncing box, for monitor bring-up.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BOX_SIZE, 32, moving-box edge length in pixels
BOX_STEP, 2, box displacement per frame per axis in pixels

Ports:
clk_i  input  1  pixel clock (~25.175 MHz)
reset_ni  input  1  reset, synchronous, active-low
x_i  input  10  horizontal pixel counter from timing stage
y_i  input  10  vertical line counter from timing stage
active_i  input  1  1 = pixel inside visible area
hsync_i  input  1  horizontal sync level (active-low), passed through
vsync_i  input  1  vertical sync level (active-low), passed through
mode_i  input  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 box
red_o  output  4  red intensity
green_o  output  4  green intensity
blue_o  output  4  blue intensity
hsync_o  output  1  hsync delayed to match RGB
vsync_o  output  1  vsync delayed to match RGB
active_o  output  1  active_i delayed to match RGB

Behaviour:
- Single clock clk_i; reset_ni sampled only on posedge clk_i (synchronous, active-low).
- Reset values:
  - red_o, green_o, blue_o = 0; hsync_o = vsync_o = 1; active_o = 0.
  - Internal state: mode_q = 0, bx = by = 0, dir_x = dir_y = +.
  - Pipeline contents are cleared.
- Reset asserted mid-frame: outputs take their reset values on the next edge. After release, output is valid 2 cycles later, and the box restarts from (0,0) at the next frame start.
- Latency: exactly 2 cycles from inputs to every output, identical for RGB, syncs and active_o.
  - Stage 1 registers x, y, active, hsync, vsync and updates the frame state.
  - Stage 2 registers colour, syncs and active.
- Frame start is defined as the cycle where active_i=1, x_i=0 and y_i=0.
  - On that edge mode_q <= mode_i and the box advances one step.
  - New mode and box position apply from the frame-start pixel onward; mode_i is ignored at all other times.
- Box motion, x axis (y axis identical with V_ACTIVE):
  - dir + and bx >= H_ACTIVE-BOX_SIZE-BOX_STEP: bx <= H_ACTIVE-BOX_SIZE, dir <= -.
  - dir - and bx <= BOX_STEP: bx <= 0, dir <= +.
  - Otherwise: bx <= bx ± BOX_STEP.
  - The box always moves, whatever the mode, and never leaves the visible area.
- Colour computed from stage-1 x and y; forced to 0,0,0 whenever stage-1 active=0.
  - Mode 0, bars:
    - idx = number of multiples of H_ACTIVE/8 that are <= x, range 0..7. Use comparisons, no divider.
    - Bars in order are white, yellow, cyan, green, magenta, red, blue, black.
    - R=F for idx in {0,1,4,5}; G=F for idx in {0,1,2,3}; B=F for idx in {0,2,4,6}; otherwise the channel is 0.
  - Mode 1, checker: all channels = F if x[5]^y[5], else 0.
  - Mode 2, gradient: R=x[9:6], G=y[8:5], B=~x[9:6].
  - Mode 3, box:
    - Inside the box (bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE, 11-bit compare): F,F,F.
    - Outside the box: 0,0,8.
- Sync inputs pass through unmodified except for the delay; no polarity change.

Decomposition:
- vga_pkg holds H_ACTIVE, V_ACTIVE and the 640x480 porch/sync constants.
- vga_pkg also holds the mode codes MODE_BARS=0, MODE_CHECKER=1, MODE_GRADIENT=2, MODE_BOX=3, and the 12-bit colour constants (white, black, background blue).
- One sub-module, vga_box_mover: owns bx/by/dir state and the bounce arithmetic, and is stepped by the frame-start pulse.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles with active_i=1 and hsync_i=0 -> RGB=0, hsync_o=1, vsync_o=1, active_o=0. After release, the first valid output appears 2 cycles later.
- Latency/bars: frame start with mode_i=0, then x=0,79,80,639 -> 2 cycles later RGB = FFF, FFF, FF0, 000, with hsync_o/active_o delayed by the same 2 cycles.
- Blanking: mode 0, active_i=0 at x=700 -> RGB=000. A toggling hsync_i appears on hsync_o exactly 2 cycles later.
- Mode latch: mode_i changes 0->1 at y=100 -> bars persist for the rest of the frame. At the next frame start, pixel (32,0) gives FFF and (0,0) gives 000.
- Box bounce: mode 3 run for 310 frames -> bx=2n until 606, then 608 at frame 304 with dir flip, then 606, 604... by reaches 448 at frame 224, then decreases.
- Box pixel: frame 10 (bx=by=20) -> pixel (20,20) = FFF, (52,20) = 008, (19,20) = 008.
